// File: rtl/k_mem_writer_if.sv
// Write-stream and read-port bundle for the k-coefficient memory.
// The master side is the host/training controller, the slave side is k_mem_writer.
interface k_mem_writer_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_valid, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/k_mem_writer.sv
// k_mem_writer: 16-entry run-time loadable coefficient memory.
// A burst of unsigned Q6.10 coefficients arrives on a valid/ready stream and is
// written to consecutive (wrapping) addresses, each stored widened to Q8.24.
// A registered read port returns the Q6.10 view of any word with one cycle latency,
// reading the old contents when it hits the word being written on the same edge.
// Optional feature macro: K_MEM_CHECKSUM_EN enables a running 16-bit sum of the
// beats of the current/last burst on the checksum output; otherwise checksum is 0.
module k_mem_writer #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 4,
    parameter int DWIDTH_TMP = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] checksum,
    k_mem_writer_if.slave     bus
);

    localparam int DEPTH      = 2 ** AWIDTH;
    // Q6.10 -> Q8.24 moves the binary point by 14 bits
    localparam int FRAC_SHIFT = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]       remaining_q, remaining_d;
    logic [DWIDTH_TMP-1:0] mem_q [DEPTH];
    logic [DWIDTH_TMP-1:0] mem_d [DEPTH];
    logic [DWIDTH-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  beat;
    logic                  start_accept;
    logic [DWIDTH_TMP-1:0] store_word;
    logic [DWIDTH_TMP-1:0] rd_word;
    logic                  unused_word_bits;

    // Widen the incoming coefficient into the stored Q8.24 word format
    assign store_word = DWIDTH_TMP'({bus.wr_data, {FRAC_SHIFT{1'b0}}});
    assign rd_word    = mem_q[bus.rd_addr];

    // The guard bits above and below the Q6.10 field are always zero and never read out
    assign unused_word_bits = ^{rd_word[DWIDTH_TMP-1:FRAC_SHIFT+DWIDTH], rd_word[FRAC_SHIFT-1:0]};

    // Burst FSM: next state, pointer/count updates and handshake outputs
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        remaining_d  = remaining_q;
        bus.wr_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        beat         = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    if (len != '0) begin
                        wr_ptr_d    = base_addr;
                        remaining_d = len;
                        state_d     = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                bus.wr_ready = 1'b1;
                busy         = 1'b1;
                if (bus.wr_valid) begin
                    beat        = 1'b1;
                    wr_ptr_d    = wr_ptr_q + AWIDTH'(1);
                    remaining_d = remaining_q - (AWIDTH + 1)'(1);
                    if (remaining_q == (AWIDTH + 1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory write: only the addressed word changes on an accepted beat
    always_comb begin
        mem_d = mem_q;
        if (beat) begin
            mem_d[wr_ptr_q] = store_word;
        end
    end

    // Read port: returns the Q6.10 field, or zero when not enabled
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = bus.rd_en;
        if (bus.rd_en) begin
            rd_data_d = rd_word[FRAC_SHIFT +: DWIDTH];
        end
    end

    // Control and read-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Coefficient storage, cleared by reset so an aborted burst leaves no residue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

`ifdef K_MEM_CHECKSUM_EN
    logic [DWIDTH-1:0] checksum_q, checksum_d;

    // Running sum: restarts when a burst is accepted, holds after the burst ends
    always_comb begin
        checksum_d = checksum_q;
        if (start_accept) begin
            checksum_d = '0;
        end else if (beat) begin
            checksum_d = checksum_q + bus.wr_data;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_k_mem_writer.sv
// Testbench for k_mem_writer: burst loads with a reference memory model and a
// read scoreboard (expected read data queued when rd_en is driven, compared when
// the registered read data comes out).
module tb_k_mem_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    k_mem_writer_if #(.DWIDTH(16), .AWIDTH(4)) bus ();

    k_mem_writer #(.DWIDTH(16), .AWIDTH(4), .DWIDTH_TMP(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .bus       (bus)
    );

    int          check_count = 0;
    int          pass_count  = 0;
    int          done_count  = 0;
    logic [15:0] model_mem [16];
    logic [3:0]  model_ptr;
    logic [15:0] model_sum;
    logic [15:0] burst_data [16];
    logic [15:0] rd_queue [$];
    logic        rd_expected;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock: update model and scoreboard from the inputs being applied,
    // then compare read-port outputs half a cycle after the edge
    task automatic step_clock();
        logic accept;
        accept = bus.wr_valid && bus.wr_ready && rst_n;
        rd_expected = bus.rd_en && rst_n;
        if (rd_expected) begin
            rd_queue.push_back(model_mem[bus.rd_addr]);
        end
        if (accept) begin
            model_mem[model_ptr] = bus.wr_data;
            model_ptr = model_ptr + 4'd1;
        end
        @(posedge clk);
        @(negedge clk);
        if (done) begin
            done_count++;
        end
        if (rd_expected) begin
            checkOutput("rd_valid_high", {31'b0, bus.rd_valid}, 32'd1);
            checkOutput("rd_queue_size", rd_queue.size(), 32'd1);
            if (rd_queue.size() != 0) begin
                checkOutput("rd_data", {16'b0, bus.rd_data}, {16'b0, rd_queue.pop_front()});
            end
        end else begin
            checkOutput("rd_valid_low", {31'b0, bus.rd_valid}, 32'd0);
            checkOutput("rd_data_idle", {16'b0, bus.rd_data}, 32'd0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 4'(a);
            step_clock();
        end
        bus.rd_en = 1'b0;
        step_clock();
    endtask

    // Run one burst of n beats from burst_data starting at base
    task automatic applyStimulus(input logic [3:0] base, input logic [4:0] n,
                                 input bit gapped, input bit poke_start);
        int          sent;
        int          guard;
        int          cycles;
        int          done_before;
        logic [15:0] sum_exp;
        done_before = done_count;
        model_ptr   = base;
        model_sum   = '0;
        start       = 1'b1;
        base_addr   = base;
        len         = n;
        step_clock();
        start  = 1'b0;
        cycles = 1;
        if (n == 0) begin
            checkOutput("len0_done", {31'b0, done}, 32'd1);
            checkOutput("len0_busy", {31'b0, busy}, 32'd0);
        end else begin
            checkOutput("start_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
            checkOutput("start_busy", {31'b0, busy}, 32'd1);
            sent  = 0;
            guard = 0;
            while (sent < int'(n) && guard < 200) begin
                bus.wr_valid = gapped ? (guard % 2 == 0) : 1'b1;
                bus.wr_data  = burst_data[sent];
                start        = poke_start && (guard == 1);
                if (start) begin
                    base_addr = 4'd9;
                    len       = 5'd1;
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    sent++;
                    model_sum = model_sum + bus.wr_data;
                end
                step_clock();
                guard++;
                cycles++;
                if (sent < int'(n)) begin
                    checkOutput("wr_ready_held", {31'b0, bus.wr_ready}, 32'd1);
                    checkOutput("done_early", {31'b0, done}, 32'd0);
                end
            end
            bus.wr_valid = 1'b0;
            start        = 1'b0;
            checkOutput("beats_sent", sent, {27'b0, n});
            checkOutput("burst_done", {31'b0, done}, 32'd1);
            checkOutput("done_busy", {31'b0, busy}, 32'd0);
            checkOutput("done_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
            if (!gapped) begin
                checkOutput("burst_cycles", cycles + 1, {27'b0, n} + 32'd2);
            end
        end
`ifdef K_MEM_CHECKSUM_EN
        sum_exp = model_sum;
`else
        sum_exp = '0;
`endif
        checkOutput("checksum", {16'b0, checksum}, {16'b0, sum_exp});
        step_clock();
        checkOutput("done_width", {31'b0, done}, 32'd0);
        checkOutput("done_count", done_count - done_before, 32'd1);
        checkOutput("checksum_hold", {16'b0, checksum}, {16'b0, sum_exp});
    endtask

    initial begin
        int done_before;
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        len          = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        model_ptr    = '0;
        model_sum    = '0;
        rd_expected  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i]  = '0;
            burst_data[i] = '0;
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        checkOutput("rst_rd_data", {16'b0, bus.rd_data}, 32'd0);
        checkOutput("rst_checksum", {16'b0, checksum}, 32'd0);
        rst_n = 1'b1;
        step_clock();
        read_all();

        $display("[TB] k-value burst at 0");
        burst_data[0] = 16'h2000;
        burst_data[1] = 16'h2000;
        burst_data[2] = 16'h1400;
        burst_data[3] = 16'h1400;
        applyStimulus(4'd0, 5'd4, 1'b0, 1'b0);
`ifdef K_MEM_CHECKSUM_EN
        checkOutput("kval_checksum", {16'b0, checksum}, 32'h6800);
`endif
        read_all();

        $display("[TB] wrapping gapped burst at 14");
        burst_data[0] = 16'h1234;
        burst_data[1] = 16'hABCD;
        burst_data[2] = 16'h0001;
        burst_data[3] = 16'hFFFF;
        applyStimulus(4'd14, 5'd4, 1'b1, 1'b0);
        read_all();

        $display("[TB] read-before-write on address 5");
        burst_data[0] = 16'h0ABC;
        applyStimulus(4'd5, 5'd1, 1'b0, 1'b0);
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 4'd5;
        burst_data[0] = 16'h0400;
        applyStimulus(4'd5, 5'd1, 1'b0, 1'b0);
        bus.rd_en = 1'b0;
        step_clock();
        read_all();

        $display("[TB] zero-length burst and ignored start");
        applyStimulus(4'd3, 5'd0, 1'b0, 1'b0);
        read_all();
        burst_data[0] = 16'h0101;
        burst_data[1] = 16'h0202;
        burst_data[2] = 16'h0303;
        burst_data[3] = 16'h0404;
        applyStimulus(4'd10, 5'd4, 1'b0, 1'b1);
        done_before = done_count;
        step_clock();
        step_clock();
        step_clock();
        checkOutput("ignored_start_done", done_count - done_before, 32'd0);
        checkOutput("ignored_start_busy", {31'b0, busy}, 32'd0);
        read_all();

        $display("[TB] full 16-beat burst");
        for (int i = 0; i < 16; i++) begin
            burst_data[i] = 16'(i * 16'h0111 + 16'h0007);
        end
        applyStimulus(4'd7, 5'd16, 1'b0, 1'b0);
        read_all();

        $display("[TB] reset mid-burst");
        done_before  = done_count;
        model_ptr    = 4'd8;
        start        = 1'b1;
        base_addr    = 4'd8;
        len          = 5'd4;
        step_clock();
        start        = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h1111;
        step_clock();
        bus.wr_data  = 16'h2222;
        step_clock();
        bus.wr_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        checkOutput("abort_checksum", {16'b0, checksum}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
        end
        step_clock();
        step_clock();
        rst_n = 1'b1;
        step_clock();
        checkOutput("abort_no_done", done_count - done_before, 32'd0);
        read_all();

        checkOutput("rd_queue_drained", rd_queue.size(), 32'd0);
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
